// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants, types and FSM states for the single-
//                precision int <-> float conversion unit.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam logic [7:0]  FP_BIAS        = 8'd127;
    localparam logic [7:0]  FP_EXP_INT_MAX = 8'd158;   // exponent of 2^31
    localparam logic [7:0]  FP_EXP_INF     = 8'd255;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        PACK  = 2'd3
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_int_convert_lzc32.sv
`default_nettype none
// ============================================================================
//  Module      : lzc32
//  Description : Combinational 32-bit leading-zero counter.
//                i_value : word to examine
//                o_count : number of leading zeros, 32 when i_value is zero
//  Revision    : 1.0  initial release
// ============================================================================
module lzc32 (
    input  logic [31:0] i_value,
    output logic [5:0]  o_count
);

    logic [5:0] w_count;

    // Scanning upward lets the most significant set bit overwrite the rest.
    always_comb begin
        w_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_value[i]) begin
                w_count = 6'(31 - i);
            end
        end
    end

    assign o_count = w_count;

endmodule
`default_nettype wire

// File: rtl/fp_int_convert.sv
`default_nettype none
// ============================================================================
//  Module      : fp_int_convert
//  Description : Multi-cycle float32 <-> int32 converter, round toward zero.
//                clk, reset          : clock, synchronous active-high reset
//                start, op, operand  : launch (op 0 = int->float, 1 = float->int)
//                result              : converted value, held until next done
//                busy / done         : in-flight flag / one-cycle completion pulse
//                inexact / invalid   : discarded bits / NaN, Inf or saturation
//  Revision    : 1.0  initial release
// ============================================================================
module fp_int_convert
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] operand,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        inexact,
    output logic        invalid
);

    // -2^31 is the only float with exponent >= 158 that fits in int32.
    localparam logic [31:0] c_FLOAT_NEG_2P31 = 32'hCF00_0000;

    conv_state_t r_state, w_next_state;

    logic        r_op;
    logic [31:0] r_operand;
    logic        r_sign;
    fp32_t       r_fp;
    logic [23:0] r_man;
    logic [7:0]  r_unb;
    logic [31:0] r_mag;
    logic [5:0]  r_lz;
    logic [31:0] r_norm;
    logic        r_sat;
    logic        r_work_inexact;

    logic [31:0] r_result;
    logic        r_done;
    logic        r_inexact;
    logic        r_invalid;

    logic [5:0]  w_lz;
    logic [7:0]  w_i2f_exp;
    logic        w_f2i_sat;
    logic [31:0] w_f2i_mag;
    logic        w_f2i_inexact;

    lzc32 u_lzc (
        .i_value (r_mag),
        .o_count (w_lz)
    );

    assign w_i2f_exp = FP_EXP_INT_MAX - {2'b00, r_lz};

    // Float->int magnitude and saturation, evaluated during SHIFT.
    always_comb begin
        w_f2i_sat     = 1'b0;
        w_f2i_mag     = 32'd0;
        w_f2i_inexact = 1'b0;
        if (r_fp.exp == FP_EXP_INF) begin
            w_f2i_sat = 1'b1;
        end else if (r_fp.exp >= FP_EXP_INT_MAX) begin
            if (r_operand == c_FLOAT_NEG_2P31) begin
                w_f2i_mag = INT_MIN;
            end else begin
                w_f2i_sat = 1'b1;
            end
        end else if (r_fp.exp < FP_BIAS) begin
            w_f2i_inexact = (r_fp.exp != 8'd0) || (r_fp.frac != 23'd0);
        end else if (r_unb >= 8'd23) begin
            w_f2i_mag = {8'd0, r_man} << (r_unb - 8'd23);
        end else begin
            w_f2i_mag     = {8'd0, r_man} >> (8'd23 - r_unb);
            w_f2i_inexact = |({8'd0, r_man} & ~(32'hFFFF_FFFF << (8'd23 - r_unb)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = PREP;
            PREP:    w_next_state = SHIFT;
            SHIFT:   w_next_state = PACK;
            PACK:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op           <= 1'b0;
            r_operand      <= 32'd0;
            r_sign         <= 1'b0;
            r_fp           <= '0;
            r_man          <= 24'd0;
            r_unb          <= 8'd0;
            r_mag          <= 32'd0;
            r_lz           <= 6'd0;
            r_norm         <= 32'd0;
            r_sat          <= 1'b0;
            r_work_inexact <= 1'b0;
            r_result       <= 32'd0;
            r_done         <= 1'b0;
            r_inexact      <= 1'b0;
            r_invalid      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The previous result stays on the port; only flags reset.
                    if (start) begin
                        r_op           <= op;
                        r_operand      <= operand;
                        r_sat          <= 1'b0;
                        r_work_inexact <= 1'b0;
                        r_inexact      <= 1'b0;
                        r_invalid      <= 1'b0;
                    end
                end
                PREP: begin
                    r_sign <= r_operand[31];
                    if (!r_op) begin
                        r_mag <= r_operand[31] ? (~r_operand + 32'd1) : r_operand;
                    end else begin
                        r_fp  <= fp32_t'(r_operand);
                        r_man <= {1'b1, r_operand[22:0]};
                        r_unb <= r_operand[30:23] - FP_BIAS;
                    end
                end
                SHIFT: begin
                    if (!r_op) begin
                        r_lz   <= w_lz;
                        r_norm <= r_mag << w_lz;
                    end else begin
                        r_mag          <= w_f2i_mag;
                        r_sat          <= w_f2i_sat;
                        r_work_inexact <= w_f2i_inexact;
                    end
                end
                PACK: begin
                    r_done <= 1'b1;
                    if (!r_op) begin
                        // A normalized nonzero magnitude always has its MSB set.
                        if (!r_norm[31]) begin
                            r_result  <= 32'd0;
                            r_inexact <= 1'b0;
                        end else begin
                            r_result  <= {r_sign, w_i2f_exp, r_norm[30:8]};
                            r_inexact <= |r_norm[7:0];
                        end
                    end else if (r_sat) begin
                        // Negative overflow and -Inf clamp low; NaN always clamps high.
                        r_result  <= ((r_fp.sign && (r_fp.exp != FP_EXP_INF)) ||
                                      (r_fp.sign && (r_fp.frac == 23'd0))) ? INT_MIN : INT_MAX;
                        r_invalid <= 1'b1;
                        r_inexact <= 1'b0;
                    end else begin
                        r_result  <= r_fp.sign ? (~r_mag + 32'd1) : r_mag;
                        r_inexact <= r_work_inexact;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign result  = r_result;
    assign inexact = r_inexact;
    assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: doc/fp_int_convert.md
Name: fp_int_convert

Overview:
- Multi-cycle single-precision conversion unit for the MIPS FP datapath: cvt.s.w (signed int32 -> float32) and cvt.w.s (float32 -> signed int32, truncate).
- Produces the float operands consumed by the FP add/sub unit; also returns FP results to the integer register file.
- Start/busy/done handshake. Fixed 4-cycle latency. Rounding is toward zero in both directions, consistent with the truncating FP adder.

Parameters:
- none; the 32-bit IEEE-754 single-precision format is fixed. Constants live in the package.

Ports:
- clk      in   1   clock
- reset    in   1   synchronous, active-high reset
- start    in   1   launch a conversion; sampled only when busy=0
- op       in   1   0 = int->float (cvt.s.w), 1 = float->int (cvt.w.s); latched with start
- operand  in   32  int32 (op=0) or float32 (op=1); latched with start
- result   out  32  conversion result; held stable until next done
- busy     out  1   high while a conversion is in flight
- done     out  1   one-cycle pulse; result/flags valid in the same cycle
- inexact  out  1   discarded nonzero bits; valid with done, held
- invalid  out  1   op=1 only: NaN, Inf or out-of-range saturation; valid with done, held

Behaviour:
- Reset: state=IDLE; result=0, busy=0, done=0, inexact=0, invalid=0; latched operand/op cleared.
- FSM: IDLE -> PREP -> SHIFT -> PACK -> IDLE.
- busy = (state != IDLE). done is registered and pulses in the first IDLE cycle after PACK.
- Start sampled on edge N -> busy high in cycles N+1..N+3 -> done=1 and result valid in cycle N+4.
- start while busy: ignored, no queueing.
- start in the same cycle done is high: accepted; the old result stays valid that cycle.
- Reset mid-operation: abort immediately, no done pulse, all outputs return to reset values.
- op=0, PREP:
  - sign = operand[31]
  - mag = sign ? (~operand + 1) : operand, 32-bit unsigned; 0x80000000 yields mag 0x80000000.
- op=0, SHIFT:
  - lz = leading-zero count of mag (0..32), from the sub-module
  - norm = mag << lz
- op=0, PACK:
  - mag == 0 -> result 0x00000000 (+0.0), inexact=0.
  - Otherwise result = {sign, 8'(158 - lz), norm[30:8]}; inexact = |norm[7:0].
- op=1, PREP: split into s, e = operand[30:23], f = operand[22:0]; m = {1, f} (24 bits); u = e - 127.
- op=1, SHIFT:
  - e == 255 (Inf/NaN) -> sat.
  - e >= 158 -> sat, except operand == 0xCF000000 (exactly -2^31) -> 0x80000000 with invalid=0.
  - e < 127 (includes zero and denormals) -> mag = 0; inexact = (e != 0 || f != 0).
  - Otherwise mag = (u >= 23) ? (m << (u-23)) : (m >> (23-u)); inexact = any bits shifted out.
- op=1, PACK:
  - sat -> result = (s && e != 255 || s && f == 0) ? 0x80000000 : 0x7FFFFFFF; invalid=1.
  - NaN always gives 0x7FFFFFFF.
  - Otherwise result = s ? -mag : mag; -0.0 converts to 0x00000000.
- Flags are cleared at each accepted start.

Decomposition:
- Package fp_pkg holds:
  - FP_BIAS = 127, FP_EXP_INT_MAX = 158, FP_EXP_INF = 255
  - INT_MAX = 0x7FFFFFFF, INT_MIN = 0x80000000
  - typedef fp32_t struct {sign, exp[7:0], frac[22:0]}
  - enum conv_state_t {IDLE, PREP, SHIFT, PACK}
- One sub-module: lzc32, combinational 32-bit leading-zero counter; 6-bit output, 32 when input is 0. It is used in the SHIFT state.

Test Plan:
- op=0, operand 0x00000001 -> done at N+4, result 0x3F800000, inexact=0; operand 0xFFFFFFFB (-5) -> 0xC0A00000.
- op=0, 0x7FFFFFFF -> 0x4EFFFFFF, inexact=1; 0x80000000 -> 0xCF000000, inexact=0; 0x00000000 -> 0x00000000.
- op=1, float->int truncation:
  - 0x40490FDB (3.14159) -> 0x00000003, inexact=1
  - 0xC2F60000 (-123.0) -> 0xFFFFFF85, inexact=0
  - 0x3F000000 (0.5) -> 0x00000000, inexact=1
- op=1, saturation and invalid cases:
  - 0x4F800000 (2^32) -> 0x7FFFFFFF, invalid=1
  - 0xCF000000 -> 0x80000000, invalid=0
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid=1
  - 0xFF800000 (-Inf) -> 0x80000000, invalid=1
- Handshake:
  - start re-pulsed at N+2 -> ignored, single done at N+4.
  - start asserted in the done cycle -> second done 4 cycles later, first result valid in its done cycle.
- Reset asserted at N+2 of an active conversion -> busy=0 next cycle, no done, result=0, flags=0.
